seq_multiplier_taint_ctl: RTL
=============================

// Module: seq_multiplier_taint_ctl
// PURPOSE
// Self-contained shift-add sequential multiplier with an integrated controller FSM and a start/done handshake.
// Every datapath bit has a taint shadow bit (_t) for information-flow tracking.
// Taint covers data flow, carry flow and control flow (multiplier bits and start).
// Successor to the split datapath/controller multiplier: parametrised width, one add+shift per cycle,
// a defined taint rule for carries, sticky control taint, synchronous reset.
// PARAMETERS
// WIDTH  4  operand width in bits; product is 2*WIDTH bits; internal sum register is 2*WIDTH+1 bits
// PORTS
// clk             in   1         clock, all state changes on posedge
// rst_n           in   1         synchronous reset, active-low
// start           in   1         request a multiply; sampled only in IDLE
// start_t         in   1         taint of start
// multiplier      in   WIDTH     operand A (unsigned)
// multiplier_t    in   WIDTH     taint of A
// multiplicand    in   WIDTH     operand B (unsigned)
// multiplicand_t  in   WIDTH     taint of B
// busy            out  1         high in RUN and DONE
// done            out  1         one-cycle pulse when product is valid
// done_t          out  1         taint of done; equals the sticky control-taint flag
// product         out  2*WIDTH   A*B; held from DONE until the next accepted start
// product_t       out  2*WIDTH   taint of product
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - State goes to IDLE; mr, md, sum, count, op_taint are cleared together with all their _t shadows.
//   - busy=0, done=0, done_t=0, product=0, product_t=0.
//   - A reset taken mid-operation abandons the operation; no done is produced.
// - IDLE:
//   - On start=1, latch mr<=multiplier and md<=multiplicand together with their _t.
//   - Clear sum and sum_t, set count=0, set op_taint<=start_t, go to RUN.
//   - Operands and start are ignored in every other state.
// - RUN: one iteration per cycle, WIDTH cycles in total.
//   - add  = mr[0] | mr_t[0]   (a tainted bit takes the add path in the shadow only; data uses mr[0]).
//   - Data: s = sum + (mr[0] ? md<<WIDTH : 0), computed at 2*WIDTH+1 bits; then sum<=s>>1 (logical, MSB fill 0).
//   - Addend taint:
//     - at = mr[0] ? md_t<<WIDTH : 0.
//     - If mr_t[0]=1, at |= {WIDTH{1}}<<WIDTH (control taint).
//   - If add: u = sum_t|at, then smear upward: u[k] |= u[k-1] for k=1..2*WIDTH (carry taint). Otherwise u = sum_t.
//   - sum_t <= u>>1, fill 0.
//   - mr<=mr>>1, mr_t<=mr_t>>1, count<=count+1.
//   - Go to DONE when count==WIDTH-1 at the posedge.
// - DONE: exactly one cycle.
//   - done=1, done_t=op_taint, go to IDLE.
// - Product outputs:
//   - product=sum[2*WIDTH-1:0].
//   - product_t = op_taint ? all-ones : sum_t[2*WIDTH-1:0].
//   - Both are registered and stable from DONE until the next start is accepted.
// - Latency: start accepted at edge 0; done is high in the cycle following edge WIDTH+1.
//   - Back-to-back starts are possible: start asserted during DONE is ignored; it is taken once in IDLE.
// - Untainted inputs give all-zero taint everywhere; an overflow into sum[2*WIDTH] cannot reach product.
// TESTING
// - W=4: A=3, B=5, all _t=0 -> done pulses WIDTH+2 cycles after start; product=15, product_t=0, done_t=0.
// - W=4: A=15, B=15 -> product=225 (8'hE1); the carry into sum bit 8 is shifted out correctly.
// - W=4: A=3, A_t=4'b0001, B=5, B_t=0, start_t=0 -> product=15, product_t=8'h3F, done_t=0.
// - W=4: A=2, B=9, start_t=1, operand taints 0 -> product=18, product_t=8'hFF, done_t=1.
// - Start asserted continuously for 20 cycles, A=1, B=7 -> busy stays high through RUN/DONE; start is ignored while busy;
//   a new operation begins the cycle after IDLE is re-entered; each done=1 carries product=7.
// - Reset: rst_n=0 for one cycle at RUN count=2 -> next cycle busy=0, product=0, product_t=0, no done pulse;
//   a fresh start then completes normally.

Source files
------------

// File: rtl/seq_multiplier_taint_ctl.sv
// Shift-add sequential multiplier with start/done handshake and per-bit taint shadows.
// Latency WIDTH+2 cycles from accepted start to done; start is ignored while busy.
module seq_multiplier_taint_ctl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               start_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  output logic               busy,
  output logic               done,
  output logic               done_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mr, mr_t, md, md_t;
  logic [SW-1:0]     sum, sum_t;
  logic [CW-1:0]     count;
  logic              op_taint;

  logic [SW-1:0]     addend, sum_nxt, at, u;
  logic              last_iter;

  assign busy      = (state_q != IDLE);
  assign last_iter = (count == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One add+shift step; taint of a tainted multiplier bit covers the whole upper half.
  always_comb begin
    addend  = mr[0] ? {1'b0, md, {WIDTH{1'b0}}} : '0;
    sum_nxt = sum + addend;
    at      = mr[0] ? {1'b0, md_t, {WIDTH{1'b0}}} : '0;
    if (mr_t[0]) at = at | {1'b0, {WIDTH{1'b1}}, {WIDTH{1'b0}}};
    u = sum_t;
    if (mr[0] | mr_t[0]) begin
      u = sum_t | at;
      // A tainted bit may carry into every bit above it.
      for (int k = 1; k <= PW; k++) u[k] = u[k] | u[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mr        <= '0;
      mr_t      <= '0;
      md        <= '0;
      md_t      <= '0;
      sum       <= '0;
      sum_t     <= '0;
      count     <= '0;
      op_taint  <= 1'b0;
      done      <= 1'b0;
      done_t    <= 1'b0;
      product   <= '0;
      product_t <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            mr       <= multiplier;
            mr_t     <= multiplier_t;
            md       <= multiplicand;
            md_t     <= multiplicand_t;
            sum      <= '0;
            sum_t    <= '0;
            count    <= '0;
            op_taint <= start_t;
          end
        end
        RUN: begin
          sum   <= sum_nxt >> 1;
          sum_t <= u >> 1;
          mr    <= mr >> 1;
          mr_t  <= mr_t >> 1;
          count <= count + CW'(1);
        end
        DONE: begin
          done_t    <= op_taint;
          product   <= sum[PW-1:0];
          product_t <= op_taint ? {PW{1'b1}} : sum_t[PW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
